// File: rtl/bist_read_checker.sv
// Read-side BIST checker: drains DEPTH words from a FIFO and compares them
// against a walking-ones pattern, reporting PASS/FAIL, error count and first bad index.
module bist_read_checker #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  BIST,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_EN,
    output logic                  DONE,
    output logic                  PASS,
    output logic                  FAIL,
    output logic [ADDR_WIDTH:0]   ERR_CNT,
    output logic [ADDR_WIDTH-1:0] FIRST_ERR_IDX
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH:0]     rd_cnt;
    logic [ADDR_WIDTH-1:0]   cmp_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    rd_vld;
    logic [ADDR_WIDTH:0]     err_cnt;
    logic [ADDR_WIDTH:0]     err_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   first_err_idx;
    logic                    done_r;
    logic                    pass_r;
    logic                    fail_r;
    logic                    do_cmp;
    logic                    mismatch;
    logic                    tmo_hit;
    logic                    issue_ok;

    function automatic logic [DATA_WIDTH-1:0] exp_word(input logic [ADDR_WIDTH-1:0] k);
        int unsigned sh;
        sh = 32'(k) % DATA_WIDTH;
        return DATA_WIDTH'(1) << sh;
    endfunction

    // Error counter sticks at all-ones rather than wrapping back to zero.
    function automatic logic [ADDR_WIDTH:0] sat_inc(input logic [ADDR_WIDTH:0] v);
        return (&v) ? v : v + (ADDR_WIDTH + 1)'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        R_EN      = 1'b0;
        do_cmp    = 1'b0;
        tmo_hit   = 1'b0;
        issue_ok  = rd_cnt < DEPTH_CNT;
        case (state)
            S_IDLE: begin
                if (BIST) state_nxt = S_READ;
            end
            S_READ: begin
                if (!BIST) begin
                    state_nxt = S_IDLE;
                end else begin
                    R_EN    = !EMPTY && issue_ok;
                    do_cmp  = rd_vld;
                    tmo_hit = EMPTY && issue_ok && (tmo_cnt == TMO_LAST);
                    if ((do_cmp && (cmp_cnt == LAST_IDX)) || tmo_hit) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!BIST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mismatch    = do_cmp && (R_DATA != exp_word(cmp_cnt));
    assign err_cnt_nxt = mismatch ? sat_inc(err_cnt) : err_cnt;

    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            state         <= S_IDLE;
            rd_cnt        <= '0;
            cmp_cnt       <= '0;
            tmo_cnt       <= '0;
            rd_vld        <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    rd_vld <= 1'b0;
                    if (BIST) begin
                        rd_cnt        <= '0;
                        cmp_cnt       <= '0;
                        tmo_cnt       <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                    end
                end
                S_READ: begin
                    // An abort drops R_EN, so rd_vld clears and any pending compare is lost.
                    rd_vld <= R_EN;
                    if (R_EN) begin
                        rd_cnt  <= rd_cnt + (ADDR_WIDTH + 1)'(1);
                        tmo_cnt <= '0;
                    end else if (BIST && EMPTY && issue_ok) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                    if (do_cmp) begin
                        cmp_cnt <= cmp_cnt + ADDR_WIDTH'(1);
                        err_cnt <= err_cnt_nxt;
                        if (mismatch && (err_cnt == '0)) first_err_idx <= cmp_cnt;
                    end
                    if (state_nxt == S_DONE) begin
                        done_r <= 1'b1;
                        pass_r <= (err_cnt_nxt == '0) && !tmo_hit;
                        fail_r <= (err_cnt_nxt != '0) || tmo_hit;
                    end
                end
                S_DONE: begin
                    rd_vld <= 1'b0;
                    if (!BIST) begin
                        done_r <= 1'b0;
                        pass_r <= 1'b0;
                        fail_r <= 1'b0;
                    end
                end
                default: rd_vld <= 1'b0;
            endcase
        end
    end

    assign DONE          = done_r;
    assign PASS          = pass_r;
    assign FAIL          = fail_r;
    assign ERR_CNT       = err_cnt;
    assign FIRST_ERR_IDX = first_err_idx;

endmodule

// File: tb/tb_bist_read_checker.sv
// Directed bench for bist_read_checker: a small FIFO model feeds walking-ones
// words (optionally corrupted) and outputs are checked against hand-derived values.
module tb_bist_read_checker;

    localparam int DW = 10;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          bist;
    logic          empty;
    logic [DW-1:0] rd_data;
    logic          r_en;
    logic          done;
    logic          pass;
    logic          fail;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_err_idx;

    logic [DW-1:0] fifo_mem [0:15];
    int            rd_ptr    = 0;
    int            en_pulses = 0;

    int checks   = 0;
    int failures = 0;

    bist_read_checker #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (10),
        .TIMEOUT   (64)
    ) dut (
        .R_CLK        (clk),
        .R_RST        (rst),
        .BIST         (bist),
        .EMPTY        (empty),
        .R_DATA       (rd_data),
        .R_EN         (r_en),
        .DONE         (done),
        .PASS         (pass),
        .FAIL         (fail),
        .ERR_CNT      (err_cnt),
        .FIRST_ERR_IDX(first_err_idx)
    );

    always #5 clk = ~clk;

    // FIFO read side: data appears the cycle after the read enable; pointer rewinds between runs.
    always @(posedge clk) begin
        if (rst || !bist) begin
            rd_ptr <= 0;
        end else if (r_en) begin
            rd_data   <= fifo_mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
            en_pulses <= en_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_pattern(input int bad_a, input int bad_b);
        for (int k = 0; k < 16; k++) begin
            if (k == bad_a || k == bad_b) fifo_mem[k] = '0;
            else fifo_mem[k] = DW'(1) << (k % DW);
        end
    endtask

    // Starts a run and steps cycle by cycle until DONE; cycle 1 follows the BIST-sampling edge.
    task automatic run(input int e_lo, input int e_hi, input int limit,
                       output int done_cyc, output int pulses, output int en_when_empty);
        int p0;
        p0            = en_pulses;
        done_cyc      = 0;
        en_when_empty = 0;
        bist          = 1'b1;
        tick();
        for (int n = 1; n <= limit; n++) begin
            empty = (n >= e_lo && n <= e_hi);
            #1;
            if (empty && r_en) en_when_empty++;
            if (done) begin
                done_cyc = n;
                break;
            end
            tick();
        end
        pulses = en_pulses - p0;
    endtask

    task automatic end_run(input string tag);
        bist = 1'b0;
        tick();
        check({tag, "_clr_done"}, done, 1'b0);
        check({tag, "_clr_pass"}, pass, 1'b0);
        check({tag, "_clr_fail"}, fail, 1'b0);
    endtask

    initial begin
        int dc;
        int np;
        int ewe;
        int p0;

        rst   = 1'b1;
        bist  = 1'b1;
        empty = 1'b0;
        load_pattern(-1, -1);

        // Reset held with BIST high
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ren", r_en, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_pass", pass, 1'b0);
            check("rst_fail", fail, 1'b0);
            check("rst_errcnt", err_cnt, 0);
            if (i == 0) tick();
        end

        // Clean run starting on the first edge after reset release
        p0  = en_pulses;
        rst = 1'b0;
        tick();
        for (int n = 1; n <= 12; n++) begin
            check($sformatf("clean_ren_c%0d", n), r_en, (n <= 10) ? 1 : 0);
            check($sformatf("clean_done_c%0d", n), done, (n == 12) ? 1 : 0);
            if (n < 12) tick();
        end
        check("clean_pulses", en_pulses - p0, 10);
        check("clean_pass", pass, 1'b1);
        check("clean_fail", fail, 1'b0);
        check("clean_errcnt", err_cnt, 0);
        tick();
        check("hold_done", done, 1'b1);
        check("hold_pass", pass, 1'b1);
        check("hold_ren", r_en, 1'b0);
        end_run("clean");

        // Word 3 corrupted
        load_pattern(3, -1);
        run(0, -1, 40, dc, np, ewe);
        check("err1_done_cyc", dc, 12);
        check("err1_fail", fail, 1'b1);
        check("err1_pass", pass, 1'b0);
        check("err1_errcnt", err_cnt, 1);
        check("err1_first", first_err_idx, 3);
        end_run("err1");
        check("err1_errcnt_hold", err_cnt, 1);

        // Words 2 and 7 corrupted: first index keeps the earlier one
        load_pattern(2, 7);
        run(0, -1, 40, dc, np, ewe);
        check("err2_done_cyc", dc, 12);
        check("err2_errcnt", err_cnt, 2);
        check("err2_first", first_err_idx, 2);
        check("err2_fail", fail, 1'b1);
        end_run("err2");

        // FIFO empty for the five cycles after word 4 is issued
        load_pattern(-1, -1);
        run(6, 10, 40, dc, np, ewe);
        check("stall_done_cyc", dc, 17);
        check("stall_ren_empty", ewe, 0);
        check("stall_pulses", np, 10);
        check("stall_pass", pass, 1'b1);
        check("stall_fail", fail, 1'b0);
        end_run("stall");

        // FIFO never delivers: timeout
        run(1, 1000, 100, dc, np, ewe);
        check("tmo_done_cyc", dc, 65);
        check("tmo_pulses", np, 0);
        check("tmo_fail", fail, 1'b1);
        check("tmo_pass", pass, 1'b0);
        check("tmo_errcnt", err_cnt, 0);
        empty = 1'b0;
        end_run("tmo");

        // Abort after five reads; the bad word 4 is still in flight and must be dropped
        load_pattern(4, -1);
        p0   = en_pulses;
        bist = 1'b1;
        tick();
        repeat (5) tick();
        bist = 1'b0;
        #1;
        check("abort_ren_now", r_en, 1'b0);
        tick();
        check("abort_ren", r_en, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_fail", fail, 1'b0);
        check("abort_errcnt", err_cnt, 0);
        check("abort_pulses", en_pulses - p0, 5);

        load_pattern(-1, -1);
        run(0, -1, 40, dc, np, ewe);
        check("rerun_done_cyc", dc, 12);
        check("rerun_pass", pass, 1'b1);
        check("rerun_pulses", np, 10);
        end_run("rerun");

        // Reset in the middle of a run after an error has been counted
        load_pattern(0, -1);
        bist = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_live_errcnt", err_cnt, 1);
        rst = 1'b1;
        tick();
        check("midrst_ren", r_en, 1'b0);
        check("midrst_errcnt", err_cnt, 0);
        check("midrst_first", first_err_idx, 0);
        check("midrst_done", done, 1'b0);
        tick();
        check("midrst_ren2", r_en, 1'b0);
        rst  = 1'b0;
        bist = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
